// File: rtl/sift_pkg.sv
// Shared SIFT stream definitions: default image geometry, keypoint record and
// collector FSM states.
package sift_pkg;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } kp_rec_t;

  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DONE} state_t;
endpackage

// File: rtl/sift_kp_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on rd_data
// while not empty, and a write is accepted at full when a read pops the same cycle.
module sift_kp_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 19
) (
  input  logic         iclk,
  input  logic         irst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             cnt;
  logic                    do_wr, do_rd;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage is reset so the head reads zero straight out of reset.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/sift_keypoint_collector.sv
// Tracks raster position of the detector stream, buffers in-border keypoints as
// {y, x} records and keeps per-frame count and overflow statistics.
module sift_keypoint_collector #(
  parameter int IMG_W  = sift_pkg::IMG_W,
  parameter int IMG_H  = sift_pkg::IMG_H,
  parameter int X_W    = sift_pkg::X_W,
  parameter int Y_W    = sift_pkg::Y_W,
  parameter int BORDER = 2,
  parameter int DEPTH  = 16
) (
  input  logic           iclk,
  input  logic           irst_n,
  input  logic           isof,
  input  logic           idata_en,
  input  logic           ikeypoint_en,
  input  logic           iready,
  input  logic           iclr_ovf,
  output logic           okp_valid,
  output logic [X_W-1:0] okp_x,
  output logic [Y_W-1:0] okp_y,
  output logic           oframe_done,
  output logic [15:0]    oframe_kp_count,
  output logic           ooverflow,
  output logic [7:0]     odrop_count
);
  import sift_pkg::*;

  localparam logic [X_W-1:0] X_LO  = X_W'(BORDER);
  localparam logic [X_W-1:0] X_HI  = X_W'(IMG_W - BORDER);
  localparam logic [X_W-1:0] X_END = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LO  = Y_W'(BORDER);
  localparam logic [Y_W-1:0] Y_HI  = Y_W'(IMG_H - BORDER);
  localparam logic [Y_W-1:0] Y_END = Y_W'(IMG_H - 1);

  state_t             state, state_nxt;
  logic [X_W-1:0]     x, cur_x;
  logic [Y_W-1:0]     y, cur_y;
  logic [15:0]        run_cnt, run_base, run_nxt;
  logic               pix, last_pix, in_border, kp_q, rd, wr_ok, drop;
  logic               fifo_full, fifo_empty;
  logic [X_W+Y_W-1:0] rd_data;

  // A start-of-frame strobe makes the coincident pixel (0,0) of the new frame.
  always_comb begin
    cur_x     = isof ? '0 : x;
    cur_y     = isof ? '0 : y;
    pix       = (state == ACTIVE) && idata_en;
    last_pix  = pix && (cur_x == X_END) && (cur_y == Y_END);
    in_border = (cur_x >= X_LO) && (cur_x < X_HI) && (cur_y >= Y_LO) && (cur_y < Y_HI);
    kp_q      = pix && ikeypoint_en && in_border;
    rd        = okp_valid && iready;
    wr_ok     = !fifo_full || rd;
    drop      = kp_q && !wr_ok;
    run_base  = isof ? '0 : run_cnt;
    run_nxt   = run_base + 16'(kp_q && wr_ok && (run_base != 16'hFFFF));
    state_nxt = state;
    case (state)
      WAIT_SOF: if (isof) state_nxt = ACTIVE;
      ACTIVE:   if (last_pix) state_nxt = DONE;
      DONE:     state_nxt = isof ? ACTIVE : WAIT_SOF;
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state           <= WAIT_SOF;
      x               <= '0;
      y               <= '0;
      run_cnt         <= '0;
      oframe_kp_count <= '0;
      ooverflow       <= 1'b0;
      odrop_count     <= '0;
    end else begin
      state <= state_nxt;
      if (state != ACTIVE) begin
        if (isof) begin
          x       <= '0;
          y       <= '0;
          run_cnt <= '0;
        end
      end else begin
        run_cnt <= run_nxt;
        if (pix) begin
          if (cur_x == X_END) begin
            x <= '0;
            y <= cur_y + Y_W'(1);
          end else begin
            x <= cur_x + X_W'(1);
            y <= cur_y;
          end
        end else if (isof) begin
          x <= '0;
          y <= '0;
        end
        if (last_pix) oframe_kp_count <= run_nxt;
      end
      // A drop in the same cycle as a clear leaves one drop recorded.
      if (drop) begin
        ooverflow   <= 1'b1;
        odrop_count <= iclr_ovf ? 8'd1 :
                       (odrop_count == 8'hFF) ? odrop_count : odrop_count + 8'd1;
      end else if (iclr_ovf) begin
        ooverflow   <= 1'b0;
        odrop_count <= '0;
      end
    end
  end

  sift_kp_fifo #(.DEPTH(DEPTH), .W(X_W+Y_W)) u_fifo (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .wr_en   (kp_q),
    .wr_data ({cur_y, cur_x}),
    .rd_en   (rd),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign okp_valid      = !fifo_empty;
  assign {okp_y, okp_x} = rd_data;
  assign oframe_done    = (state == DONE);
endmodule

// File: tb/tb_sift_keypoint_collector.sv
// Scoreboard bench for sift_keypoint_collector on an 8x8 frame with a one-pixel border.
module tb_sift_keypoint_collector;
  import sift_pkg::*;

  logic        iclk = 1'b0, irst_n = 1'b1;
  logic        isof = 1'b0, idata_en = 1'b0, ikeypoint_en = 1'b0, iready = 1'b0, iclr_ovf = 1'b0;
  logic        okp_valid, oframe_done, ooverflow;
  logic [9:0]  okp_x;
  logic [8:0]  okp_y;
  logic [15:0] oframe_kp_count;
  logic [7:0]  odrop_count;

  int      n_cmp = 0, n_err = 0, done_cnt = 0;
  kp_rec_t exp_q[$];
  kp_rec_t e;

  always #5 iclk = ~iclk;

  sift_keypoint_collector #(.IMG_W(8), .IMG_H(8), .X_W(10), .Y_W(9), .BORDER(1), .DEPTH(16)) dut (
    .iclk(iclk), .irst_n(irst_n), .isof(isof), .idata_en(idata_en), .ikeypoint_en(ikeypoint_en),
    .iready(iready), .iclr_ovf(iclr_ovf), .okp_valid(okp_valid), .okp_x(okp_x), .okp_y(okp_y),
    .oframe_done(oframe_done), .oframe_kp_count(oframe_kp_count), .ooverflow(ooverflow),
    .odrop_count(odrop_count)
  );

  // Monitor: every transfer is popped from the expected queue and compared.
  always @(negedge iclk) begin
    if (irst_n) begin
      if (oframe_done) done_cnt++;
      if (okp_valid && iready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rec: got (%0d,%0d), none expected", okp_x, okp_y);
        end else begin
          e = exp_q.pop_front();
          if ({okp_y, okp_x} !== e) begin
            n_err++;
            $display("FAIL rec: got (%0d,%0d) expected (%0d,%0d)", okp_x, okp_y, e.x, e.y);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int px, input int py);
    kp_rec_t r;
    r.x = 10'(px);
    r.y = 9'(py);
    exp_q.push_back(r);
  endtask

  task automatic pix(input logic kp);
    idata_en = 1'b1;
    ikeypoint_en = kp;
    step();
    idata_en = 1'b0;
    ikeypoint_en = 1'b0;
  endtask

  task automatic sof();
    isof = 1'b1;
    step();
    isof = 1'b0;
  endtask

  task automatic frame(input logic [63:0] kp, input int exp_cnt, input string nm, input int lat_at);
    sof();
    for (int p = 0; p < 64; p++) begin
      pix(kp[p]);
      if (p == lat_at) begin
        chk({nm, "_lat_valid"}, okp_valid, 1);
        chk({nm, "_lat_x"}, okp_x, p % 8);
        chk({nm, "_lat_y"}, okp_y, p / 8);
      end
    end
    chk({nm, "_done"}, oframe_done, 1);
    chk({nm, "_count"}, oframe_kp_count, exp_cnt);
    step();
    chk({nm, "_done_pulse"}, oframe_done, 0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_valid"}, okp_valid, 0);
    chk({nm, "_x"}, okp_x, 0);
    chk({nm, "_y"}, okp_y, 0);
    chk({nm, "_done"}, oframe_done, 0);
    chk({nm, "_count"}, oframe_kp_count, 0);
    chk({nm, "_ovf"}, ooverflow, 0);
    chk({nm, "_drops"}, odrop_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m;
    int n, d0;
    #2 irst_n = 1'b0;
    step();
    step();
    chk_reset("rst");
    irst_n = 1'b1;
    step();

    // Pixels before any start-of-frame must be ignored.
    iready = 1'b1;
    repeat (20) pix(1'b1);
    chk("pre_sof_valid", okp_valid, 0);

    // Single keypoint at pixel 10 -> (2,1), visible one cycle later.
    push(2, 1);
    frame(64'd1 << 10, 1, "t1", 10);

    // Border rejects: only (1,1) survives.
    m = '0;
    m[0] = 1'b1; m[31] = 1'b1; m[9] = 1'b1; m[59] = 1'b1; m[63] = 1'b1;
    push(1, 1);
    frame(m, 1, "t2", -1);

    // 20 in-border keypoints with no reads: 16 stored, 4 dropped.
    iready = 1'b0;
    m = '0;
    n = 0;
    for (int yy = 1; yy <= 4; yy++)
      for (int xx = 1; xx <= 6; xx++)
        if (n < 20) begin
          m[yy*8+xx] = 1'b1;
          if (n < 16) push(xx, yy);
          n++;
        end
    frame(m, 16, "t3", -1);
    chk("t3_ovf", ooverflow, 1);
    chk("t3_drops", odrop_count, 4);

    // Full FIFO with a simultaneous read accepts the write.
    sof();
    for (int p = 0; p < 9; p++) pix(1'b0);
    push(1, 1);
    iready = 1'b1;
    pix(1'b1);
    iready = 1'b0;
    chk("t4_no_drop", odrop_count, 4);
    pix(1'b1);
    chk("t4_still_full_drop", odrop_count, 5);
    iclr_ovf = 1'b1;
    step();
    iclr_ovf = 1'b0;
    chk("t4_clr_ovf", ooverflow, 0);
    chk("t4_clr_drops", odrop_count, 0);
    iclr_ovf = 1'b1;
    pix(1'b1);
    iclr_ovf = 1'b0;
    chk("t4_clr_vs_drop_ovf", ooverflow, 1);
    chk("t4_clr_vs_drop_cnt", odrop_count, 1);

    // Drain: 16 records back-to-back.
    iready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_b2b_valid", okp_valid, 1);
      step();
    end
    chk("t4_drained", okp_valid, 0);
    chk("t4_queue", exp_q.size(), 0);

    // Asynchronous reset mid-frame with a non-empty FIFO.
    iready = 1'b0;
    sof();
    for (int p = 0; p < 11; p++) pix(p == 9 || p == 10);
    #2 irst_n = 1'b0;
    #1;
    chk_reset("t6_rst");
    step();
    irst_n = 1'b1;
    exp_q.delete();
    iready = 1'b1;
    repeat (20) pix(1'b1);
    chk("t6_wait_sof_valid", okp_valid, 0);

    // Restart mid-frame after 5 keypoints: no done, count unchanged.
    for (int xx = 1; xx <= 5; xx++) push(xx, 1);
    sof();
    for (int p = 0; p < 14; p++) pix(p >= 9);
    d0 = done_cnt;
    m = '0;
    m[18] = 1'b1; m[45] = 1'b1; m[54] = 1'b1;
    push(2, 2); push(5, 5); push(6, 6);
    frame(m, 3, "t5", -1);
    chk("t5_count_kept_before", done_cnt, d0 + 1);
    step();
    chk("t5_single_done", done_cnt, d0 + 1);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
